// File: rtl/arinc429_word_checker.sv
// ARINC 429 receive-word parity checker with a small valid/ready output FIFO and
// saturating good/bad word counters. Define ARINC_ERR_FWD_EN to forward bad words flagged by out_err.
module arinc429_word_checker #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              odd_mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_err,
    output logic [CNT_W-1:0]  good_cnt,
    output logic [CNT_W-1:0]  bad_cnt,
    input  logic              cnt_clr
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_reg, rd_ptr_reg;
    logic [WORD_W-1:0] data_mem [DEPTH];
    logic              full, empty;
    logic              parity_good, accept, push, pop;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                   (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

    assign in_ready    = !full;
    assign out_valid   = !empty;
    assign parity_good = ((^in_data) == odd_mode);
    assign accept      = in_valid && in_ready;
    assign pop         = out_valid && out_ready;

`ifdef ARINC_ERR_FWD_EN
    logic err_mem [DEPTH];

    assign push = accept;

    always_ff @(posedge clk) begin
        if (push) begin
            err_mem[wr_ptr_reg[AW-1:0]] <= !parity_good;
        end
    end

    assign out_err = err_mem[rd_ptr_reg[AW-1:0]];
`else
    // Bad words never occupy a slot, so there is no flag to store.
    assign push    = accept && parity_good;
    assign out_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg[AW-1:0]] <= in_data;
        end
    end

    assign out_data = data_mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Index 0 counts good words, index 1 bad words; clear beats increment.
    logic [1:0][CNT_W-1:0] cnt_reg;
    logic [1:0]            cnt_inc;

    assign cnt_inc = {accept && !parity_good, accept && parity_good};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (cnt_clr) begin
                    cnt_reg[i] <= '0;
                end else if (cnt_inc[i] && (cnt_reg[i] != {CNT_W{1'b1}})) begin
                    cnt_reg[i] <= cnt_reg[i] + 1'b1;
                end
            end
        end
    end

    assign good_cnt = cnt_reg[0];
    assign bad_cnt  = cnt_reg[1];

endmodule

// File: tb/tb_arinc429_word_checker.sv
// Directed self-checking bench for arinc429_word_checker (DEPTH=4, CNT_W=4 to reach saturation).
module tb_arinc429_word_checker;
    localparam int WORD_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              odd_mode;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_err;
    logic [CNT_W-1:0]  good_cnt;
    logic [CNT_W-1:0]  bad_cnt;
    logic              cnt_clr;

    int n_checks = 0;
    int n_errors = 0;

    arinc429_word_checker #(
        .WORD_W(WORD_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .odd_mode (odd_mode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_err  (out_err),
        .good_cnt (good_cnt),
        .bad_cnt  (bad_cnt),
        .cnt_clr  (cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    // Odd-parity-good word: MSB is the complement of the XOR of the low 31 bits.
    function automatic logic [31:0] goodw(input int v);
        logic [30:0] low;
        low = v[30:0];
        return {~^low, low};
    endfunction

    initial begin
        rst_n     = 1'b0;
        odd_mode  = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;

        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_good_cnt", 32'(good_cnt), 32'd0);
        check("rst_bad_cnt", 32'(bad_cnt), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Odd mode: two good words then one bad word, consumer always ready.
        odd_mode  = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h8000_0000;
        check("t1_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("t1_w1_valid", 32'(out_valid), 32'd1);
        check("t1_w1_data", out_data, 32'h8000_0000);
        check("t1_w1_err", 32'(out_err), 32'd0);
        check("t1_w1_good", 32'(good_cnt), 32'd1);
        in_data = 32'h0000_0001;
        tick();
        check("t1_w2_valid", 32'(out_valid), 32'd1);
        check("t1_w2_data", out_data, 32'h0000_0001);
        in_data = 32'h0000_0000;
        tick();
        check("t1_good", 32'(good_cnt), 32'd2);
        check("t1_bad", 32'(bad_cnt), 32'd1);
`ifdef ARINC_ERR_FWD_EN
        check("t1_w3_valid", 32'(out_valid), 32'd1);
        check("t1_w3_data", out_data, 32'h0000_0000);
        check("t1_w3_err", 32'(out_err), 32'd1);
`else
        check("t1_w3_dropped", 32'(out_valid), 32'd0);
`endif
        in_valid = 1'b0;
        tick();
        check("t1_drained", 32'(out_valid), 32'd0);

        // Even mode: only the all-zero word is good.
        clear_counters();
        check("t2_clr_good", 32'(good_cnt), 32'd0);
        check("t2_clr_bad", 32'(bad_cnt), 32'd0);
        odd_mode = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h8000_0000;
        tick();
        in_data = 32'h0000_0001;
        tick();
        in_data = 32'h0000_0000;
        tick();
        in_valid = 1'b0;
        check("t2_good", 32'(good_cnt), 32'd1);
        check("t2_bad", 32'(bad_cnt), 32'd2);
        check("t2_head_valid", 32'(out_valid), 32'd1);
        check("t2_head_data", out_data, 32'h0000_0000);
        check("t2_head_err", 32'(out_err), 32'd0);
        tick();

        // Back-pressure: fill four slots, hold the fifth word off, then drain in order.
        clear_counters();
        odd_mode  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h1 << i;
            check($sformatf("t3_ready_%0d", i), 32'(in_ready), 32'd1);
            tick();
        end
        check("t3_full", 32'(in_ready), 32'd0);
        in_data = 32'h0000_0010;
        tick();
        check("t3_held_ready", 32'(in_ready), 32'd0);
        check("t3_held_good", 32'(good_cnt), 32'd4);
        check("t3_head_1", out_data, 32'h0000_0001);
        out_ready = 1'b1;
        tick();
        check("t3_ready_back", 32'(in_ready), 32'd1);
        check("t3_no_accept", 32'(good_cnt), 32'd4);
        check("t3_head_2", out_data, 32'h0000_0002);
        tick();
        in_valid = 1'b0;
        check("t3_good_5", 32'(good_cnt), 32'd5);
        check("t3_head_4", out_data, 32'h0000_0004);
        tick();
        check("t3_head_8", out_data, 32'h0000_0008);
        tick();
        check("t3_head_10", out_data, 32'h0000_0010);
        tick();
        check("t3_empty", 32'(out_valid), 32'd0);

        // Streaming across pointer wrap, then saturation and clear-over-increment.
        clear_counters();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            in_data = goodw(i);
            tick();
            check($sformatf("t4_valid_%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("t4_data_%0d", i), out_data, goodw(i));
        end
        check("t4_saturated", 32'(good_cnt), 32'd15);
        cnt_clr = 1'b1;
        in_data = goodw(99);
        tick();
        cnt_clr  = 1'b0;
        in_valid = 1'b0;
        check("t4_clr_wins", 32'(good_cnt), 32'd0);
        tick();
        check("t4_empty", 32'(out_valid), 32'd0);

        // Asynchronous reset with three words queued.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'h1 << i;
            tick();
        end
        in_valid = 1'b0;
        check("t5_pre_good", 32'(good_cnt), 32'd3);
        check("t5_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_ready", 32'(in_ready), 32'd1);
        check("t5_rst_good", 32'(good_cnt), 32'd0);
        check("t5_rst_bad", 32'(bad_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t5_post_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
